fifo_mem_ctrl: RTL and testbench

FIFO_MEM_CTRL -- requirements
Module: fifo_mem_ctrl

---
 rtl/fifo_mem_ctrl_pkg.sv | 14 +
 rtl/fifo_mem_ctrl_ptr.sv | 27 ++
 rtl/fifo_mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_fifo_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_mem_ctrl_pkg.sv
// Shared definitions for the FIFO controller: default geometry and FSM encoding.
package fifo_mem_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_RAM_DEPTH  = 2 ** DEF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_mem_ctrl_ptr.sv
// Wrapping ADDR_WIDTH-bit pointer with increment enable; wraps at 2**ADDR_WIDTH.
module fifo_ptr
  import fifo_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_en,
  output logic [ADDR_WIDTH-1:0] ptr
);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_en) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_mem_ctrl.sv
// FIFO controller in front of a dual-port RAM: registered strobes at the accepting edge,
// read data returned two edges after the pop; rejected requests pulse overflow/underflow.
module fifo_mem_ctrl
  import fifo_mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RAM_DEPTH  = DEF_RAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address_write,
  output logic [ADDR_WIDTH-1:0] mem_address_read,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_valid_out,
  input  logic                  mem_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  err
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_read_q, mem_read_d;
  logic [ADDR_WIDTH-1:0] mem_address_write_q, mem_address_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_read_q, mem_address_read_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  err_q, err_d;
  logic                  push_acc, pop_acc;
  logic [ADDR_WIDTH-1:0] wptr, rptr;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
    .clk    (clk),
    .rst    (RESET),
    .inc_en (push_acc),
    .ptr    (wptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
    .clk    (clk),
    .rst    (RESET),
    .inc_en (pop_acc),
    .ptr    (rptr)
  );

  always_comb begin
    state_d             = state_q;
    count_d             = count_q;
    mem_write_d         = 1'b0;
    mem_read_d          = 1'b0;
    mem_address_write_d = mem_address_write_q;
    mem_address_read_d  = mem_address_read_q;
    mem_data_d          = mem_data_q;
    data_out_d          = data_out_q;
    valid_out_d         = 1'b0;
    overflow_d          = 1'b0;
    underflow_d         = 1'b0;
    err_d               = err_q | mem_err;
    push_acc            = 1'b0;
    pop_acc             = 1'b0;

    case (state_q)
      ST_INIT: state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        push_acc    = push && !full;
        pop_acc     = pop && !empty;
        overflow_d  = push && full;
        underflow_d = pop && empty;
        if (mem_err) state_d = ST_FAULT;
      end
      default: state_d = ST_FAULT;
    endcase

    if (push_acc) begin
      mem_write_d         = 1'b1;
      mem_address_write_d = wptr;
      mem_data_d          = data_in;
    end
    if (pop_acc) begin
      mem_read_d         = 1'b1;
      mem_address_read_d = rptr;
    end

    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Returns arriving during INIT belong to pops issued before a reset; drop them.
    if (mem_valid_out && state_q != ST_INIT) begin
      valid_out_d = 1'b1;
      data_out_d  = mem_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q             <= ST_INIT;
      count_q             <= '0;
      mem_write_q         <= 1'b0;
      mem_read_q          <= 1'b0;
      mem_address_write_q <= '0;
      mem_address_read_q  <= '0;
      mem_data_q          <= '0;
      data_out_q          <= '0;
      valid_out_q         <= 1'b0;
      overflow_q          <= 1'b0;
      underflow_q         <= 1'b0;
      err_q               <= 1'b0;
    end else begin
      state_q             <= state_d;
      count_q             <= count_d;
      mem_write_q         <= mem_write_d;
      mem_read_q          <= mem_read_d;
      mem_address_write_q <= mem_address_write_d;
      mem_address_read_q  <= mem_address_read_d;
      mem_data_q          <= mem_data_d;
      data_out_q          <= data_out_d;
      valid_out_q         <= valid_out_d;
      overflow_q          <= overflow_d;
      underflow_q         <= underflow_d;
      err_q               <= err_d;
    end
  end

  assign mem_write         = mem_write_q;
  assign mem_read          = mem_read_q;
  assign mem_address_write = mem_address_write_q;
  assign mem_address_read  = mem_address_read_q;
  assign mem_data          = mem_data_q;
  assign data_out          = data_out_q;
  assign valid_out         = valid_out_q;
  assign overflow          = overflow_q;
  assign underflow         = underflow_q;
  assign err               = err_q;

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Bench for fifo_mem_ctrl with a behavioural dual-port RAM and a queue-based FIFO model.
module tb_fifo_mem_ctrl;
  import fifo_mem_ctrl_pkg::*;

  localparam int DW    = DEF_DATA_WIDTH;
  localparam int AW    = DEF_ADDR_WIDTH;
  localparam int DEPTH = DEF_RAM_DEPTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RESET, push, pop;
  logic [DW-1:0] data_in;
  logic          mem_write, mem_read;
  logic [AW-1:0] mem_address_write, mem_address_read;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_data_out = '0;
  logic          mem_valid_out = 1'b0;
  logic          mem_err;
  logic [DW-1:0] data_out;
  logic          valid_out, full, empty, overflow, underflow, err;
  logic          inject = 1'b0;

  fifo_mem_ctrl dut (
    .clk               (clk),
    .RESET             (RESET),
    .push              (push),
    .data_in           (data_in),
    .pop               (pop),
    .mem_write         (mem_write),
    .mem_read          (mem_read),
    .mem_address_write (mem_address_write),
    .mem_address_read  (mem_address_read),
    .mem_data          (mem_data),
    .mem_data_out      (mem_data_out),
    .mem_valid_out     (mem_valid_out),
    .mem_err           (mem_err),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .full              (full),
    .empty             (empty),
    .overflow          (overflow),
    .underflow         (underflow),
    .err               (err)
  );

  // Memory: one-edge write, one-edge registered read with a valid strobe.
  logic [DW-1:0] ram [DEPTH];
  assign mem_err = inject | (mem_write && mem_read && (mem_address_write == mem_address_read));
  always @(posedge clk) begin
    mem_valid_out <= 1'b0;
    if (mem_write) ram[mem_address_write] <= mem_data;
    if (mem_read) begin
      mem_data_out  <= ram[mem_address_read];
      mem_valid_out <= 1'b1;
    end
  end

  int total = 0, passed = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Reference model state
  typedef struct { logic [DW-1:0] d; int c; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] fifo_m[$];
  int            cyc = 0, mstate = 0, valid_seen = 0;
  logic          m_err = 0, e_mw = 0, e_mr = 0, e_ovf = 0, e_unf = 0;
  logic [AW-1:0] m_wptr = 0, m_rptr = 0, e_waddr = 0, e_raddr = 0;
  logic [DW-1:0] e_wdata = 0;

  task automatic step(input logic p, input logic [DW-1:0] d, input logic q);
    logic ap, aq;
    exp_t e;
    push = p; data_in = d; pop = q;
    @(posedge clk);
    cyc++;
    ap = (mstate == 1) && p && (fifo_m.size() < DEPTH);
    aq = (mstate == 1) && q && (fifo_m.size() > 0);
    if (RESET) begin
      mstate = 0; fifo_m.delete(); exp_q.delete(); m_err = 0;
      m_wptr = 0; m_rptr = 0; e_waddr = 0; e_raddr = 0; e_wdata = 0;
      e_mw = 0; e_mr = 0; e_ovf = 0; e_unf = 0;
    end else begin
      e_ovf = (mstate == 1) && p && (fifo_m.size() == DEPTH);
      e_unf = (mstate == 1) && q && (fifo_m.size() == 0);
      e_mw = ap; e_mr = aq;
      if (aq) begin
        e.d = fifo_m.pop_front(); e.c = cyc; exp_q.push_back(e);
        e_raddr = m_rptr; m_rptr++;
      end
      if (ap) begin
        fifo_m.push_back(d); e_waddr = m_wptr; e_wdata = d; m_wptr++;
      end
      if (inject) m_err = 1;
      if (mstate == 0) mstate = 1;
      else if (mstate == 1 && inject) mstate = 2;
    end
    @(negedge clk);
  endtask

  task automatic cmp_outs(input string tag);
    chk({tag, " mem_write"}, mem_write, e_mw);
    chk({tag, " mem_read"}, mem_read, e_mr);
    chk({tag, " waddr"}, mem_address_write, e_waddr);
    chk({tag, " raddr"}, mem_address_read, e_raddr);
    chk({tag, " mem_data"}, mem_data, e_wdata);
    chk({tag, " overflow"}, overflow, e_ovf);
    chk({tag, " underflow"}, underflow, e_unf);
    chk({tag, " full"}, full, fifo_m.size() == DEPTH);
    chk({tag, " empty"}, empty, fifo_m.size() == 0);
    chk({tag, " err"}, err, m_err);
    if (mem_write && mem_read) chk({tag, " addr distinct"}, mem_address_write != mem_address_read, 1);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, " mem_write"}, mem_write, 0);
    chk({tag, " mem_read"}, mem_read, 0);
    chk({tag, " waddr"}, mem_address_write, 0);
    chk({tag, " raddr"}, mem_address_read, 0);
    chk({tag, " mem_data"}, mem_data, 0);
    chk({tag, " data_out"}, data_out, 0);
    chk({tag, " valid_out"}, valid_out, 0);
    chk({tag, " ovf/unf"}, {overflow, underflow}, 0);
    chk({tag, " err"}, err, 0);
    chk({tag, " empty"}, empty, 1);
    chk({tag, " full"}, full, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (valid_out) begin
      valid_seen++;
      if (exp_q.size() == 0) chk("unexpected valid_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("data_out", data_out, e.d);
        chk("valid latency", cyc - e.c, 2);
      end
    end
  end

  typedef struct {
    logic p; logic [DW-1:0] d; logic q;
    logic x_full; logic x_ovf; logic x_mw; logic [AW-1:0] x_waddr;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int vs;
    logic [AW-1:0] prev_w, prev_r;
    logic wrap_w, wrap_r;

    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, DW'(i + 1), 1'b0, (i == 7), 1'b0, 1'b1, AW'(i)};
    tbl[8] = '{1'b1, 6'h3F, 1'b0, 1'b1, 1'b1, 1'b0, 3'd7};

    RESET = 1; push = 0; pop = 0; data_in = 0;
    step(0, 0, 0); step(0, 0, 0);
    rst_chk("reset");
    RESET = 0;
    step(1, 6'h2A, 0);  // INIT cycle: push must be ignored
    cmp_outs("init");

    // Fill to full then one rejected push
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].p, tbl[i].d, tbl[i].q);
      chk($sformatf("fill%0d full", i), full, tbl[i].x_full);
      chk($sformatf("fill%0d overflow", i), overflow, tbl[i].x_ovf);
      chk($sformatf("fill%0d mem_write", i), mem_write, tbl[i].x_mw);
      chk($sformatf("fill%0d waddr", i), mem_address_write, tbl[i].x_waddr);
      cmp_outs("fill");
    end
    step(0, 0, 0);
    chk("overflow one cycle", overflow, 0);
    chk("still full", full, 1);

    // Drain
    for (int i = 0; i < 8; i++) begin step(0, 0, 1); cmp_outs("drain"); end
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("drain valid count", valid_seen, 8);
    chk("drain empty", empty, 1);
    chk("drain scoreboard empty", exp_q.size(), 0);

    // Underflow
    vs = valid_seen;
    step(0, 0, 1);
    cmp_outs("underflow");
    chk("underflow pulse", underflow, 1);
    chk("underflow no read", mem_read, 0);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0); cmp_outs("post-underflow"); end
    chk("underflow no valid", valid_seen, vs);

    // Steady count of 3 with simultaneous push/pop
    for (int i = 0; i < 3; i++) begin step(1, DW'(8'h21 + i), 0); cmp_outs("pre3"); end
    wrap_w = 0; wrap_r = 0; prev_w = mem_address_write; prev_r = mem_address_read;
    for (int i = 0; i < 10; i++) begin
      step(1, DW'(8'h30 + i), 1);
      cmp_outs("pushpop");
      if (prev_w == 3'd7 && mem_address_write == 3'd0) wrap_w = 1;
      if (prev_r == 3'd7 && mem_address_read == 3'd0) wrap_r = 1;
      prev_w = mem_address_write; prev_r = mem_address_read;
    end
    chk("write addr wrapped", wrap_w, 1);
    chk("read addr wrapped", wrap_r, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("count3 not empty before pop%0d", i), empty, 0);
      step(0, 0, 1); cmp_outs("pop3");
    end
    chk("count3 empty", empty, 1);
    step(0, 0, 1);
    chk("count3 underflow", underflow, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("count3 scoreboard empty", exp_q.size(), 0);

    // Reset with a pop in flight
    step(1, 6'h11, 0); step(1, 6'h12, 0); step(0, 0, 0);
    vs = valid_seen;
    step(0, 0, 1);
    RESET = 1; step(0, 0, 0); RESET = 0;
    rst_chk("midreset");
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("midreset no late valid", valid_seen, vs);
    rst_chk("midreset idle");
    step(1, 6'h15, 0); cmp_outs("post-reset push");
    step(0, 0, 1); cmp_outs("post-reset pop");
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("post-reset valid", valid_seen, vs + 1);

    // Fault
    step(1, 6'h05, 0); step(1, 6'h06, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0);
    inject = 1; step(0, 0, 0); inject = 0;
    chk("err set", err, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 6'h07, 1);
      cmp_outs("fault");
      chk("fault strobes", {mem_write, mem_read}, 0);
    end
    chk("err sticky", err, 1);
    RESET = 1; step(0, 0, 0);
    rst_chk("fault reset");
    RESET = 0; step(0, 0, 0);
    rst_chk("fault reset idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
